// File: rtl/lb_byte_gateway_if.sv
// Byte-stream and local-bus signals of the byte gateway.
// master: the gateway side; slave: the stream source/sink and bus slave.
interface lb_byte_gateway_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_abort;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [23:0] addr;
  logic        control_strobe;
  logic        control_rd;
  logic [31:0] data_out;
  logic [31:0] data_in;

  modport master (
    input  rx_data, rx_valid, rx_abort, tx_ready, data_in,
    output rx_ready, tx_data, tx_valid, addr, control_strobe, control_rd, data_out
  );

  modport slave (
    output rx_data, rx_valid, rx_abort, tx_ready, data_in,
    input  rx_ready, tx_data, tx_valid, addr, control_strobe, control_rd, data_out
  );
endinterface

// File: rtl/lb_byte_gateway.sv
// Parses 8-byte command records into local-bus strobes and returns one 8-byte reply per record.
// state   | meaning
// COLLECT | shifting in command bytes, rx_ready high
// ISSUE   | one-cycle bus strobe
// WAIT_RD | counting read latency, then capture data_in
// REPLY   | emitting the 8 reply bytes
module lb_byte_gateway #(
  parameter int READ_DELAY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lb_byte_gateway_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int DW = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT_RD, REPLY} state_t;

  state_t        state, state_nxt;
  logic [2:0]    byte_cnt;
  logic [55:0]   rec;
  logic [7:0]    ctl;
  logic [23:0]   addr_q;
  logic [31:0]   data_out_q;
  logic [DW-1:0] dly;
  logic [55:0]   tx_shift;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic [2:0]    tx_idx;
  logic          rx_ready_c, strobe_c, rd_c;
  logic          tx_fire;

  assign tx_fire = tx_valid_q & bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rx_ready_c = 1'b0;
    strobe_c   = 1'b0;
    rd_c       = 1'b0;
    case (state)
      COLLECT: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid && !bus.rx_abort && byte_cnt == 3'd7) state_nxt = ISSUE;
      end
      ISSUE: begin
        strobe_c  = 1'b1;
        rd_c      = ctl[4];
        state_nxt = ctl[4] ? WAIT_RD : REPLY;
      end
      WAIT_RD: if (dly == '0) state_nxt = REPLY;
      REPLY:   if (tx_fire && tx_idx == 3'd7) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      rec        <= '0;
      ctl        <= '0;
      addr_q     <= '0;
      data_out_q <= '0;
      dly        <= '0;
      tx_shift   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_idx     <= '0;
      txn_count  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.rx_abort) begin
            byte_cnt <= '0;
          end else if (bus.rx_valid) begin
            rec      <= {rec[47:0], bus.rx_data};
            byte_cnt <= byte_cnt + 3'd1;
            // rec already holds bytes 0-6 when the last byte arrives
            if (byte_cnt == 3'd7) begin
              ctl        <= rec[55:48];
              addr_q     <= rec[47:24];
              data_out_q <= {rec[23:0], bus.rx_data};
            end
          end
        end
        ISSUE: begin
          dly <= DW'(READ_DELAY - 1);
          if (!ctl[4]) begin
            tx_data_q  <= ctl;
            tx_shift   <= {addr_q, data_out_q};
            tx_valid_q <= 1'b1;
            tx_idx     <= '0;
          end
        end
        WAIT_RD: begin
          if (dly == '0) begin
            tx_data_q  <= ctl;
            tx_shift   <= {addr_q, bus.data_in};
            tx_valid_q <= 1'b1;
            tx_idx     <= '0;
          end else begin
            dly <= dly - DW'(1);
          end
        end
        REPLY: begin
          if (tx_fire) begin
            if (tx_idx == 3'd7) begin
              tx_valid_q <= 1'b0;
              txn_count  <= txn_count + CNT_W'(1);
            end else begin
              tx_data_q <= tx_shift[55:48];
              tx_shift  <= {tx_shift[47:0], 8'h00};
              tx_idx    <= tx_idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready       = rx_ready_c;
  assign bus.control_strobe = strobe_c;
  assign bus.control_rd     = rd_c;
  assign bus.addr           = addr_q;
  assign bus.data_out       = data_out_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.tx_valid       = tx_valid_q;
  assign busy               = !(state == COLLECT && byte_cnt == 3'd0);

endmodule

// File: tb/tb_lb_byte_gateway.sv
// Scoreboard bench for lb_byte_gateway: directed records, expected strobes and reply bytes queued at issue.
module tb_lb_byte_gateway;
  localparam int READ_DELAY = 2;
  // Narrow counter so the wrap is reached with a handful of records.
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  logic [CNT_W-1:0] txn_count;

  lb_byte_gateway_if bus();

  lb_byte_gateway #(.READ_DELAY(READ_DELAY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic toggle_en = 1'b0;

  typedef struct packed {logic rd; logic [23:0] addr; logic [31:0] data;} strobe_t;
  logic [7:0] exp_tx[$];
  strobe_t    exp_st[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: registers the read data twice after the strobe.
  function automatic logic [31:0] mem_rd(input logic [23:0] a);
    return (a == 24'h0) ? 32'h48656C6C : {a[7:0], a[15:8], a[23:16], 8'hA5};
  endfunction

  logic [31:0] p1 = 32'hDEADBEEF, p2 = 32'hDEADBEEF;
  always @(posedge clk) begin
    p1 <= (bus.control_strobe && bus.control_rd) ? mem_rd(bus.addr) : 32'hDEADBEEF;
    p2 <= p1;
  end
  assign bus.data_in = p2;

  // Monitor
  logic prev_strobe = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0, st_rd = 1'b0;
  logic [7:0] prev_data = 8'h0;
  int st_cyc = 0;
  strobe_t st_exp;
  logic [7:0] b_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0;
    end else begin
      if (bus.control_strobe) begin
        check("strobe_back_to_back", prev_strobe, 0);
        checks++;
        if (exp_st.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got addr %0h rd %0b, required no strobe", bus.addr, bus.control_rd);
        end else begin
          st_exp = exp_st.pop_front();
          if ({bus.control_rd, bus.addr, bus.data_out} !== st_exp) begin
            errors++;
            $display("FAIL strobe_fields: got rd=%0b addr=%0h data=%0h required rd=%0b addr=%0h data=%0h",
                     bus.control_rd, bus.addr, bus.data_out, st_exp.rd, st_exp.addr, st_exp.data);
          end
        end
        st_cyc = cyc;
        st_rd  = bus.control_rd;
      end
      if (bus.tx_valid && !prev_valid)
        check("tx_latency", 64'(cyc - st_cyc), st_rd ? 64'(READ_DELAY + 1) : 64'd1);
      if (bus.tx_valid) check("rx_ready_in_reply", bus.rx_ready, 0);
      if (prev_stall) check("stall_hold", bus.tx_data, prev_data);
      if (bus.tx_valid && bus.tx_ready) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got byte %0h, required no byte", bus.tx_data);
        end else begin
          b_exp = exp_tx.pop_front();
          if (bus.tx_data !== b_exp) begin
            errors++;
            $display("FAIL tx_byte: got %0h expected %0h", bus.tx_data, b_exp);
          end
        end
      end
      prev_strobe = bus.control_strobe;
      prev_valid  = bus.tx_valid;
      prev_stall  = bus.tx_valid && !bus.tx_ready;
      prev_data   = bus.tx_data;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (toggle_en) bus.tx_ready = ~bus.tx_ready;
  end

  task automatic send_byte(input logic [7:0] b, input logic ab);
    int n = 0;
    bus.rx_data = b; bus.rx_valid = 1'b1; bus.rx_abort = ab;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL rx_accept_timeout: byte %0h not accepted within 200 cycles", b);
        break;
      end
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_abort = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                          input logic [31:0] rep, input logic want_reply);
    logic [63:0] r;
    logic [63:0] e;
    r = {c, a, d};
    e = {c, a, rep};
    exp_st.push_back({c[4], a, d});
    if (want_reply) for (int i = 7; i >= 0; i--) exp_tx.push_back(e[i*8 +: 8]);
    for (int i = 7; i >= 0; i--) send_byte(r[i*8 +: 8], 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_tx.size() != 0) && n < 400) begin
      @(negedge clk); n++;
    end
    check("idle_reached", n < 400, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rx_ready"}, bus.rx_ready, 1);
    check({tag, "_tx_valid"}, bus.tx_valid, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_strobe"}, bus.control_strobe, 0);
    check({tag, "_rd"}, bus.control_rd, 0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_data_out"}, bus.data_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_txn_count"}, txn_count, 0);
  endtask

  initial begin
    int n;
    bus.rx_data = 8'h0; bus.rx_valid = 1'b0; bus.rx_abort = 1'b0; bus.tx_ready = 1'b1;
    #3 rst_n = 1'b0;
    #2 check_reset("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Write
    send_rec(8'h00, 24'h050002, 32'h00000080, 32'h00000080, 1'b1);
    wait_idle();
    check("write_txn_count", txn_count, 1);
    check("write_addr_hold", bus.addr, 24'h050002);
    check("write_data_out_hold", bus.data_out, 32'h00000080);

    // Read from address 0
    send_rec(8'h10, 24'h000000, 32'hAABBCCDD, 32'h48656C6C, 1'b1);
    wait_idle();
    check("read_txn_count", txn_count, 2);

    // Replies under toggling backpressure
    toggle_en = 1'b1;
    send_rec(8'h03, 24'h123456, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    send_rec(8'h9F, 24'hABCDEF, 32'h01020304, 32'hEFCDABA5, 1'b1);
    wait_idle();
    toggle_en = 1'b0;
    bus.tx_ready = 1'b1;
    check("stall_txn_count", txn_count, 4);

    // Abort: partial record, then a byte accepted together with abort
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    check("partial_busy", busy, 1);
    send_byte(8'h06, 1'b1);
    check("abort_busy", busy, 0);
    send_rec(8'h01, 24'h000010, 32'h11223344, 32'h11223344, 1'b1);
    wait_idle();
    check("abort_txn_count", txn_count, 5);

    // Reset while waiting for read data
    exp_st.push_back({1'b1, 24'h123456, 32'h0});
    for (int i = 7; i >= 0; i--) begin
      logic [63:0] r;
      r = {8'h10, 24'h123456, 32'h0};
      send_byte(r[i*8 +: 8], 1'b0);
    end
    n = 0;
    while (!bus.control_strobe && n < 50) begin
      @(negedge clk); n++;
    end
    check("rd_strobe_seen", bus.control_strobe, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset("midrst");
    exp_tx.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_tx_valid", bus.tx_valid, 0);
    check("post_rst_txn_count", txn_count, 0);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // Counter wrap through all-ones
    for (int i = 0; i < 15; i++)
      send_rec(8'h00, 24'(i + 32), 32'(i * 3), 32'(i * 3), 1'b1);
    wait_idle();
    check("count_all_ones", txn_count, 4'hF);
    send_rec(8'h00, 24'h0000AA, 32'h55AA55AA, 32'h55AA55AA, 1'b1);
    wait_idle();
    check("count_wrap", txn_count, 4'h0);

    repeat (5) @(negedge clk);
    check("queues_drained", 64'(exp_tx.size() + exp_st.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/lb_byte_gateway.md
# lb_byte_gateway

Byte-stream-to-local-bus master that sits directly upstream of the Marble local-bus slave. It parses 8-byte command records arriving on a byte stream (UDP payload or UART path) and drives `addr`/`control_strobe`/`control_rd`/`data_out`. It captures `data_in` after a fixed read latency and emits an 8-byte reply record per command on an output byte stream with valid/ready handshake. One transaction is in flight at a time.

## Interface
Parameters:
- `READ_DELAY`, 2: cycles from the strobe cycle to the cycle in which `data_in` is sampled (slave registers twice).
- `CNT_W`, 16: width of the transaction counter.

Ports:
- `clk`  in  1  local-bus clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  command byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  byte accepted when `rx_valid & rx_ready`.
- `rx_abort`  in  1  upstream packet ended or errored; discards the partial record.
- `tx_data`  out  8  reply byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  byte consumed when `tx_valid & tx_ready`.
- `addr`  out  24  local-bus address.
- `control_strobe`  out  1  one-cycle transaction strobe.
- `control_rd`  out  1  1 = read, 0 = write; qualified by strobe.
- `data_out`  out  32  write data.
- `data_in`  in  32  read data from the slave.
- `busy`  out  1  high in any state other than COLLECT with byte count 0.
- `txn_count`  out  CNT_W  completed transactions, wraps.

## Operation
- Record format, big-endian: byte0 control (bit4 = read, other bits echoed unchanged), bytes1-3 address[23:0], bytes4-7 data[31:0]. Data bytes are present on reads too and are ignored.
- States: COLLECT → ISSUE → (WAIT_RD) → REPLY → COLLECT.
- COLLECT: `rx_ready`=1. Shifts accepted bytes into an 8-byte record, with a 3-bit byte counter. Goes to ISSUE on acceptance of byte7.
- ISSUE: one cycle. `control_strobe`=1, `control_rd`=ctl[4], `addr`/`data_out` from the record. A write goes to REPLY. A read goes to WAIT_RD.
- WAIT_RD: counts READ_DELAY cycles after the strobe cycle. Latches `data_in` in cycle strobe+READ_DELAY, then goes to REPLY.
- REPLY: emits ctl, addr[23:16], addr[15:8], addr[7:0], then data[31:24..7:0]. Data is the captured read data, or the write data echoed for a write. On acceptance of the 8th byte: `txn_count`+1, go to COLLECT.
- `rx_ready`=0 outside COLLECT. Backpressure is the only flow control; there is no input FIFO.
- `rx_abort` in COLLECT clears the byte counter, and a byte accepted in the same cycle is discarded. In ISSUE/WAIT_RD/REPLY it is ignored: the transaction completes and its reply is sent.
- `addr` and `data_out` hold their last values between transactions. `control_rd` is 0 except during ISSUE of a read.
- `txn_count` wraps from all-ones to 0.

## Timing
- Reset (async assert, sync release): state COLLECT, byte count 0, `rx_ready`=1, `tx_valid`=0, `tx_data`=0, `control_strobe`=0, `control_rd`=0, `addr`=0, `data_out`=0, `busy`=0, `txn_count`=0.
- Reset mid-transaction drops the record and any pending reply; no strobe after release until a new full record arrives.
- Byte7 accepted at edge E; strobe is high in the cycle after E.
- Write: `tx_valid` rises the cycle after the strobe.
- Read: `tx_valid` rises the cycle after the `data_in` sample cycle, i.e. strobe+READ_DELAY+1.
- `tx_data`/`tx_valid` are registered and stable until handshake; there is no combinational path from `tx_ready` to `tx_data`.
- Minimum record-to-record period with no stalls: 8 (rx) + 1 (issue) + [READ_DELAY] + 8 (tx) cycles.
- `control_strobe` is never high on consecutive cycles.

## Test plan
- Write: bytes 00 05 00 02 00 00 00 80 → one strobe, `control_rd`=0, `addr`=050002, `data_out`=00000080; reply echoes same 8 bytes; `txn_count`=1.
- Read, slave model with 2-cycle latency returning 48656C6C at addr 000000: bytes 10 00 00 00 xx xx xx xx → reply 10 00 00 00 48 65 6C 6C; `tx_valid` rises exactly strobe+3.
- `tx_ready` toggling 1/0 each cycle during reply → bytes unchanged while stalled, exact order, `rx_ready`=0 throughout, no second strobe.
- `rx_abort` after 5 bytes, then a full write record → exactly one strobe, using the second record's fields.
- `rst_n` pulsed low during WAIT_RD → all outputs at reset values immediately, no reply emitted, `txn_count`=0.
- Preload `txn_count`=FFFF via 65535 back-to-back writes (or force) plus one more → `txn_count`=0000.
